// File: rtl/demux_stream_if.sv
// Bus for the registered stream demux: one valid/ready input stream fanned out to
// N_OUT independently back-pressured output channels, plus the drop counter.
interface demux_stream_if #(
    parameter int N_OUT  = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(N_OUT)
);
    logic                    e;
    logic [SEL_W-1:0]        a;
    logic [DATA_W-1:0]       in_data;
    logic                    in_last;
    logic                    in_valid;
    logic                    in_ready;
    logic [N_OUT*DATA_W-1:0] c_data;
    logic [N_OUT-1:0]        c_last;
    logic [N_OUT-1:0]        c_valid;
    logic [N_OUT-1:0]        c_ready;
    logic [15:0]             drop_cnt;

    modport master (
        output e, a, in_data, in_last, in_valid, c_ready,
        input  in_ready, c_data, c_last, c_valid, drop_cnt
    );

    modport slave (
        input  e, a, in_data, in_last, in_valid, c_ready,
        output in_ready, c_data, c_last, c_valid, drop_cnt
    );
endinterface

// File: rtl/demux_stream.sv
// Registered 1-to-N stream demux. Select/enable lock for the length of a packet;
// each output channel is a one-entry register with its own back-pressure.
module demux_stream_ch #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic              last,
    input  logic              ready,
    output logic [DATA_W-1:0] q_data,
    output logic              q_last,
    output logic              q_valid
);
    // load wins over drain so a simultaneous drain+reload stays valid
    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_last  <= 1'b0;
        end else if (load) begin
            q_valid <= 1'b1;
            q_data  <= data;
            q_last  <= last;
        end else if (ready) begin
            q_valid <= 1'b0;
        end
    end
endmodule

module demux_stream #(
    parameter  int N_OUT  = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(N_OUT)
) (
    input  logic          clk,
    input  logic          rst,
    demux_stream_if.slave s
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t                        state, state_nx;
    logic [SEL_W-1:0]              lock_sel, sel_eff;
    logic                          lock_en, en_eff;
    logic                          is_drop, in_ready, accept, lock_load;
    logic [15:0]                   drop_q;
    logic [N_OUT-1:0]              hit, free, load;
    logic [N_OUT-1:0][DATA_W-1:0]  ch_data;
    logic [N_OUT-1:0]              ch_last, ch_valid;

    always_comb begin
        sel_eff = s.a;
        en_eff  = s.e;
        if (state == BUSY) begin
            sel_eff = lock_sel;
            en_eff  = lock_en;
        end
        // out-of-range selects only exist when N_OUT is not a power of two
        is_drop = !en_eff || !(32'(sel_eff) < N_OUT);
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        assign hit[k]  = !is_drop && (sel_eff == SEL_W'(k));
        assign free[k] = !ch_valid[k] || s.c_ready[k];
        assign load[k] = s.in_valid && hit[k] && free[k];
    end

    always_comb begin
        state_nx  = state;
        in_ready  = is_drop || |(hit & free);
        accept    = s.in_valid && in_ready;
        lock_load = accept && (state == IDLE) && !s.in_last;
        if (accept) begin
            if (state == IDLE && !s.in_last)
                state_nx = BUSY;
            else if (state == BUSY && s.in_last)
                state_nx = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lock_sel <= '0;
            lock_en  <= 1'b0;
            drop_q   <= '0;
        end else begin
            state <= state_nx;
            if (lock_load) begin
                lock_sel <= s.a;
                lock_en  <= s.e;
            end
            if (s.in_valid && is_drop && drop_q != 16'hFFFF)
                drop_q <= drop_q + 16'd1;
        end
    end

    demux_stream_ch #(.DATA_W(DATA_W)) u_ch [N_OUT-1:0] (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .data    (s.in_data),
        .last    (s.in_last),
        .ready   (s.c_ready),
        .q_data  (ch_data),
        .q_last  (ch_last),
        .q_valid (ch_valid)
    );

    assign s.in_ready = in_ready;
    assign s.c_data   = ch_data;
    assign s.c_last   = ch_last;
    assign s.c_valid  = ch_valid;
    assign s.drop_cnt = drop_q;
endmodule

// File: tb/tb_demux_stream.sv
// Scoreboard bench for demux_stream: a packet-lock model predicts each routed beat,
// a negedge monitor pops and compares every output transfer.
module tb_demux_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    demux_stream_if #(.N_OUT(4), .DATA_W(8)) bus ();
    demux_stream_if #(.N_OUT(3), .DATA_W(8)) bus3 ();

    demux_stream #(.N_OUT(4), .DATA_W(8)) dut  (.clk(clk), .rst(rst), .s(bus));
    demux_stream #(.N_OUT(3), .DATA_W(8)) dut3 (.clk(clk), .rst(rst), .s(bus3));

    // expected {data, last} per channel, plus the bench's own packet-lock model
    logic [8:0] expq [4][$];
    logic       m_busy;
    logic [1:0] m_sel;
    logic       m_en;
    int         m_drop;

    task automatic mon(input logic [3:0] mask);
        logic [8:0] got, exp;
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (mask[k] && bus.c_valid[k] && bus.c_ready[k]) begin
                    got = {bus.c_data[k*8 +: 8], bus.c_last[k]};
                    checks++;
                    if (expq[k].size() == 0) begin
                        errors++;
                        $display("FAIL out_unexpected ch%0d got %h required none", k, got);
                    end else begin
                        exp = expq[k].pop_front();
                        if (got !== exp) begin
                            errors++;
                            $display("FAIL out_data ch%0d got %h required %h", k, got, exp);
                        end
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon(4'hF);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) expq[k].delete();
        m_busy = 1'b0;
        m_sel  = '0;
        m_en   = 1'b0;
        m_drop = 0;
    endtask

    task automatic model_accept(input logic [1:0] av, input logic ev,
                                input logic [7:0] d, input logic lst);
        logic [1:0] sel;
        logic       en;
        sel = m_busy ? m_sel : av;
        en  = m_busy ? m_en  : ev;
        if (en) expq[sel].push_back({d, lst});
        else    m_drop++;
        if (!m_busy && !lst) begin
            m_busy = 1'b1;
            m_sel  = av;
            m_en   = ev;
        end else if (m_busy && lst) begin
            m_busy = 1'b0;
        end
    endtask

    // Drive one beat and wait (bounded) for acceptance; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [1:0] av, input logic ev, input logic [7:0] d,
                             input logic lst, output int waits);
        bus.a = av; bus.e = ev; bus.in_data = d; bus.in_last = lst; bus.in_valid = 1'b1;
        waits = 0;
        #1;
        while (!bus.in_ready) begin
            if (waits == 50) begin
                checks++; errors++;
                $display("FAIL accept_timeout in_ready got 0 required 1 after %0d cycles", waits);
                break;
            end
            cyc(); #1;
            waits++;
        end
        if (bus.in_ready) model_accept(av, ev, d, lst);
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.e = 0; bus.a = 0; bus.in_data = 0; bus.in_last = 0; bus.in_valid = 0; bus.c_ready = 4'hF;
        bus3.e = 0; bus3.a = 0; bus3.in_data = 0; bus3.in_last = 0; bus3.in_valid = 0; bus3.c_ready = 3'h7;
        model_reset();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        checks++; if (bus.c_valid !== 4'h0) begin errors++; $display("FAIL reset_c_valid got %h required 0", bus.c_valid); end
        checks++; if (bus.c_data !== 32'h0) begin errors++; $display("FAIL reset_c_data got %h required 0", bus.c_data); end
        checks++; if (bus.c_last !== 4'h0) begin errors++; $display("FAIL reset_c_last got %h required 0", bus.c_last); end
        checks++; if (bus.drop_cnt !== 16'h0) begin errors++; $display("FAIL reset_drop_cnt got %h required 0", bus.drop_cnt); end
    endtask

    task automatic test_route();
        int w;
        logic [3:0] expv;
        for (int a = 0; a < 4; a++) begin
            send_beat(2'(a), 1'b1, 8'(8'hA0 + a), 1'b1, w);
            expv = 4'(1 << a);
            checks++; if (bus.c_valid !== expv) begin errors++; $display("FAIL route_valid a=%0d got %h required %h", a, bus.c_valid, expv); end
            checks++; if (bus.c_data[a*8 +: 8] !== 8'(8'hA0 + a)) begin errors++; $display("FAIL route_data a=%0d got %h required %h", a, bus.c_data[a*8 +: 8], 8'(8'hA0 + a)); end
            cyc();
            checks++; if (bus.c_valid !== 4'h0) begin errors++; $display("FAIL route_pulse a=%0d got %h required 0", a, bus.c_valid); end
        end
    endtask

    task automatic test_sweep();
        int w;
        logic [3:0] expv;
        logic [2:0] combo;
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            send_beat(combo[1:0], combo[2], 8'(8'h50 + i), 1'b1, w);
            expv = combo[2] ? 4'(1 << combo[1:0]) : 4'h0;
            checks++; if (bus.c_valid !== expv) begin errors++; $display("FAIL sweep_valid e/a=%0d got %h required %h", i, bus.c_valid, expv); end
            cyc();
        end
        checks++; if (bus.drop_cnt !== 16'd4) begin errors++; $display("FAIL sweep_drop_cnt got %0d required 4", bus.drop_cnt); end
    endtask

    task automatic test_lock();
        int w;
        logic [1:0] av;
        logic       ev;
        for (int b = 0; b < 4; b++) begin
            av = (b == 0) ? 2'd2 : 2'd1;
            ev = (b == 0);
            send_beat(av, ev, 8'(8'hC0 + b), (b == 3), w);
            checks++; if (w !== 0) begin errors++; $display("FAIL lock_bubble beat%0d got %0d waits required 0", b, w); end
            checks++; if (bus.c_valid !== 4'b0100) begin errors++; $display("FAIL lock_valid beat%0d got %h required 4", b, bus.c_valid); end
            checks++; if (bus.c_last[2] !== (b == 3)) begin errors++; $display("FAIL lock_last beat%0d got %b required %b", b, bus.c_last[2], (b == 3)); end
        end
        checks++; if (bus.drop_cnt !== 16'(m_drop)) begin errors++; $display("FAIL lock_drop_cnt got %0d required %0d", bus.drop_cnt, m_drop); end
        cyc();
    endtask

    task automatic test_back_to_back();
        int w;
        bus.c_ready = 4'b1101;
        send_beat(2'd1, 1'b1, 8'hB1, 1'b0, w);
        checks++; if (bus.c_valid[1] !== 1'b1) begin errors++; $display("FAIL bp_first_valid got %b required 1", bus.c_valid[1]); end
        bus.a = 2'd1; bus.e = 1'b1; bus.in_data = 8'hB2; bus.in_last = 1'b1; bus.in_valid = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b required 0", bus.in_ready); end
        cyc(); #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_hold got %b required 0", bus.in_ready); end
        checks++; if (bus.c_data[15:8] !== 8'hB1) begin errors++; $display("FAIL bp_hold_data got %h required b1", bus.c_data[15:8]); end
        bus.c_ready = 4'hF;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release got %b required 1", bus.in_ready); end
        mon(4'b0010);
        model_accept(2'd1, 1'b1, 8'hB2, 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        checks++; if (bus.c_valid[1] !== 1'b1 || bus.c_data[15:8] !== 8'hB2) begin errors++; $display("FAIL bp_reload got v=%b d=%h required v=1 d=b2", bus.c_valid[1], bus.c_data[15:8]); end
        cyc();
        checks++; if (bus.c_valid[1] !== 1'b0) begin errors++; $display("FAIL bp_drain got %b required 0", bus.c_valid[1]); end
    endtask

    task automatic test_reset_mid();
        int w;
        send_beat(2'd0, 1'b1, 8'hD0, 1'b0, w);
        send_beat(2'd0, 1'b1, 8'hD1, 1'b0, w);
        bus.a = 2'd0; bus.e = 1'b1; bus.in_data = 8'hD2; bus.in_last = 1'b0; bus.in_valid = 1'b1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        model_reset();
        checks++; if (bus.c_valid !== 4'h0) begin errors++; $display("FAIL rstmid_valid got %h required 0", bus.c_valid); end
        checks++; if (bus.drop_cnt !== 16'h0) begin errors++; $display("FAIL rstmid_drop_cnt got %0d required 0", bus.drop_cnt); end
        send_beat(2'd3, 1'b1, 8'hD3, 1'b1, w);
        checks++; if (bus.c_valid !== 4'b1000) begin errors++; $display("FAIL rstmid_restart got %h required 8", bus.c_valid); end
        cyc();
    endtask

    task automatic test_n3();
        bus3.a = 2'd3; bus3.e = 1'b1; bus3.in_data = 8'hE3; bus3.in_last = 1'b1; bus3.in_valid = 1'b1;
        #1;
        checks++; if (bus3.in_ready !== 1'b1) begin errors++; $display("FAIL n3_ready got %b required 1", bus3.in_ready); end
        cyc();
        bus3.in_valid = 1'b0;
        checks++; if (bus3.drop_cnt !== 16'd1) begin errors++; $display("FAIL n3_drop_cnt got %0d required 1", bus3.drop_cnt); end
        checks++; if (bus3.c_valid !== 3'b000) begin errors++; $display("FAIL n3_valid got %b required 000", bus3.c_valid); end
        bus3.a = 2'd2; bus3.in_data = 8'hE2; bus3.in_valid = 1'b1;
        cyc();
        bus3.in_valid = 1'b0;
        checks++; if (bus3.c_valid !== 3'b100 || bus3.c_data[23:16] !== 8'hE2) begin errors++; $display("FAIL n3_route got v=%b d=%h required v=100 d=e2", bus3.c_valid, bus3.c_data[23:16]); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_route();
        test_sweep();
        test_lock();
        test_back_to_back();
        test_reset_mid();
        test_n3();
        cyc(); cyc();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (expq[k].size() != 0) begin
                errors++;
                $display("FAIL lost_beats ch%0d got %0d pending required 0", k, expq[k].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
